gpio_periph: RTL and testbench

- Parametrised, memory-mapped general-purpose I/O peripheral. It is the successor to the single 8-bit write-only output latch.
- Provides WIDTH bidirectional pins with atomic set/clear/toggle, per-pin direction, two-flop input synchronisers, per-pin edge-detect interrupts, registered read-back and byte-strobed writes.
- Sits on the core's data-memory bus next to DataMemory and decodes its own address window.

---
 rtl/gpio_periph.sv | 157 +++++++++++++++
 tb/tb_gpio_periph.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gpio_periph.sv
// gpio_periph: memory-mapped GPIO block with WIDTH bidirectional pins.
// Registers: OUT, SET, CLR, TGL, DIR, IN, IRQ_EN, IRQ_STATUS (RW1C), IRQ_POL.
// Inputs pass through a two-flop synchroniser and a history flop for edge detection.
// Bus handshake: a write commits on the posedge where write=1 and the address
// hits the window. A read samples on the posedge where read=1 and the address
// hits, and data_out holds that value for the following cycle. data_out is 0
// on every other cycle. There is no back-pressure, so every access takes one cycle.
module gpio_periph #(
  parameter int               WIDTH     = 8,
  parameter logic [9:0]       BASE_ADDR = 10'h50,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       address,
  input  logic [31:0]      data_in,
  input  logic [3:0]       wstrb,
  input  logic             write,
  input  logic             read,
  output logic [31:0]      data_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] OFF_OUT  = 4'd0;
  localparam logic [3:0] OFF_SET  = 4'd1;
  localparam logic [3:0] OFF_CLR  = 4'd2;
  localparam logic [3:0] OFF_TGL  = 4'd3;
  localparam logic [3:0] OFF_DIR  = 4'd4;
  localparam logic [3:0] OFF_IN   = 4'd5;
  localparam logic [3:0] OFF_IEN  = 4'd6;
  localparam logic [3:0] OFF_ISTS = 4'd7;
  localparam logic [3:0] OFF_IPOL = 4'd8;

  // Architectural state
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_st_q, irq_st_d;
  logic [WIDTH-1:0] irq_pol_q, irq_pol_d;
  logic [31:0]      data_out_q, data_out_d;

  // Input path: two synchroniser stages plus the edge-history flop
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

  // Bus decode
  logic [3:0]       offset;
  logic             hit;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      byte_mask;
  logic [31:0]      wdata;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] wm;

  // Edge detect
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;

  // Read mux
  logic [WIDTH-1:0] rd_field;
  logic [31:0]      rd_val;
  logic [WIDTH-1:0] w1c;

  // The window is the 64-byte block selected by address[9:6]; address[1:0] is ignored.
  assign offset    = address[5:2];
  assign hit       = (address[9:6] == BASE_ADDR[9:6]) && (offset < 4'd9);
  assign wr_en     = write && hit;
  assign rd_en     = read && hit;
  assign byte_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign wdata     = data_in & byte_mask;
  assign wd        = wdata[WIDTH-1:0];
  assign wm        = byte_mask[WIDTH-1:0];

  // Bits above WIDTH and the byte-lane address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{address[1:0], wdata, byte_mask};

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;
  assign evt  = (irq_pol_q & fall) | (~irq_pol_q & rise);

  // Next-state for the register file: one offset is written per cycle at most
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    irq_en_d  = irq_en_q;
    irq_pol_d = irq_pol_q;
    w1c       = '0;
    if (wr_en) begin
      case (offset)
        OFF_OUT:  out_d     = (out_q & ~wm) | wd;
        OFF_SET:  out_d     = out_q | wd;
        OFF_CLR:  out_d     = out_q & ~wd;
        OFF_TGL:  out_d     = out_q ^ wd;
        OFF_DIR:  dir_d     = (dir_q & ~wm) | wd;
        OFF_IEN:  irq_en_d  = (irq_en_q & ~wm) | wd;
        OFF_ISTS: w1c       = wd;
        OFF_IPOL: irq_pol_d = (irq_pol_q & ~wm) | wd;
        default:  ;
      endcase
    end
    // An event arriving together with a clear of the same bit keeps the bit set
    irq_st_d = (irq_st_q & ~w1c) | evt;
  end

  // Read mux selects the pre-write value, zero-extended to 32 bits
  always_comb begin
    rd_field = '0;
    rd_val   = '0;
    case (offset)
      OFF_OUT:  rd_field = out_q;
      OFF_DIR:  rd_field = dir_q;
      OFF_IN:   rd_field = sync2_q;
      OFF_IEN:  rd_field = irq_en_q;
      OFF_ISTS: rd_field = irq_st_q;
      OFF_IPOL: rd_field = irq_pol_q;
      default:  rd_field = '0;
    endcase
    rd_val[WIDTH-1:0] = rd_field;
    data_out_d = rd_en ? rd_val : 32'd0;
  end

  // State registers with synchronous active-low reset overriding any access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= OUT_RESET;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_st_q   <= '0;
      irq_pol_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      data_out_q <= '0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_st_q   <= irq_st_d;
      irq_pol_q  <= irq_pol_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(irq_st_q & irq_en_q);

endmodule

// File: tb/tb_gpio_periph.sv
// tb_gpio_periph: scoreboard bench for gpio_periph at WIDTH=8, OUT_RESET=8'hA5.
module tb_gpio_periph;

  localparam int         W    = 8;
  localparam logic [9:0] BASE = 10'h50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    address = '0;
  logic [31:0]   data_in = '0;
  logic [3:0]    wstrb = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [31:0]   data_out;
  logic [W-1:0]  gpio_in = '0;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic        rd_seen = 1'b0;

  gpio_periph #(.WIDTH(W), .BASE_ADDR(BASE), .OUT_RESET(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .wstrb(wstrb), .write(write), .read(read), .data_out(data_out),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] reg_addr(input logic [3:0] off);
    return {BASE[9:6], off, 2'b00};
  endfunction

  // Driver tasks: inputs change on the falling edge, commit on the next rising edge
  task automatic bus_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    address = reg_addr(off);
    data_in = d;
    wstrb   = s;
    write   = 1'b1;
    @(negedge clk);
    write   = 1'b0;
    wstrb   = '0;
  endtask

  task automatic bus_read(input logic [3:0] off, input logic [31:0] exp);
    @(negedge clk);
    address = reg_addr(off);
    read    = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    read    = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: a read accepted at a posedge produces data_out for the next cycle
  always @(posedge clk) rd_seen <= read && rst_n;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 32'd1);
      else check("read_data", data_out, exp_q.pop_front());
    end
  end

  initial begin
    // Reset state
    cycles(3);
    rst_n = 1'b1;
    check("rst_gpio_out", 32'(gpio_out), 32'h0000_00A5);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_data_out", data_out, 32'h0);
    for (int i = 0; i < 10; i++)
      bus_read(4'(i), (i == 0) ? 32'h0000_00A5 : 32'h0);

    // Atomic set/clear/toggle
    bus_write(4'd0, 32'h0000_000F, 4'hF); check("out_wr", 32'(gpio_out), 32'h0F);
    bus_write(4'd1, 32'h0000_0030, 4'hF); check("out_set", 32'(gpio_out), 32'h3F);
    bus_write(4'd2, 32'h0000_0001, 4'hF); check("out_clr", 32'(gpio_out), 32'h3E);
    bus_write(4'd3, 32'h0000_00FF, 4'hF); check("out_tgl", 32'(gpio_out), 32'hC1);
    bus_read(4'd0, 32'h0000_00C1);
    bus_read(4'd1, 32'h0);

    // Byte strobes and width truncation
    bus_write(4'd4, 32'hFFFF_FFFF, 4'b0001); check("dir_oe", 32'(gpio_oe), 32'hFF);
    bus_read(4'd4, 32'h0000_00FF);
    bus_write(4'd4, 32'h0000_0000, 4'b0000);
    bus_read(4'd4, 32'h0000_00FF);
    bus_write(4'd0, 32'h0000_1200, 4'b0010); check("out_strb_hi", 32'(gpio_out), 32'hC1);
    bus_write(4'd9, 32'h0000_0000, 4'hF); check("out_off9", 32'(gpio_out), 32'hC1);

    // Rising-edge interrupt on pin 2
    bus_write(4'd6, 32'h0000_0004, 4'hF);
    bus_write(4'd8, 32'h0000_0000, 4'hF);
    @(negedge clk); gpio_in[2] = 1'b1;
    cycles(2); check("irq_early", 32'(irq), 32'h0);
    cycles(1); check("irq_rise", 32'(irq), 32'h1);
    bus_read(4'd7, 32'h0000_0004);
    bus_read(4'd5, 32'h0000_0004);
    bus_write(4'd7, 32'h0000_0004, 4'hF); check("irq_w1c", 32'(irq), 32'h0);
    bus_read(4'd7, 32'h0);

    // Falling-edge event on pin 3 colliding with a W1C of bit 3
    @(negedge clk); gpio_in[3] = 1'b1;
    cycles(4);
    bus_read(4'd7, 32'h0000_0008);
    bus_write(4'd7, 32'h0000_0008, 4'hF);
    bus_write(4'd8, 32'h0000_0008, 4'hF);
    bus_read(4'd7, 32'h0);
    @(negedge clk); gpio_in[3] = 1'b0;
    cycles(1);
    bus_write(4'd7, 32'h0000_0008, 4'hF);
    bus_read(4'd7, 32'h0000_0008);
    check("irq_masked", 32'(irq), 32'h0);

    // Raise bit 2 again so two bits are pending
    @(negedge clk); gpio_in[2] = 1'b0;
    cycles(4);
    @(negedge clk); gpio_in[2] = 1'b1;
    cycles(4);
    bus_write(4'd0, 32'h0000_00FF, 4'hF);
    bus_write(4'd6, 32'h0000_000C, 4'hF);
    bus_read(4'd7, 32'h0000_000C);
    check("irq_pending", 32'(irq), 32'h1);
    check("out_ff", 32'(gpio_out), 32'hFF);

    // Mid-stream reset overriding a concurrent read
    @(negedge clk);
    rst_n   = 1'b0;
    gpio_in = '0;
    address = reg_addr(4'd7);
    read    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    read  = 1'b0;
    check("mrst_gpio_out", 32'(gpio_out), 32'h0000_00A5);
    check("mrst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("mrst_irq", 32'(irq), 32'h0);
    check("mrst_data_out", data_out, 32'h0);
    bus_read(4'd7, 32'h0);
    bus_read(4'd0, 32'h0000_00A5);
    bus_read(4'd8, 32'h0);
    cycles(2);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
